carwash_ctrl: RTL
=================

Name: carwash_ctrl

Overview:
- Second-generation car-wash controller.
- Replaces the external spray/rinse timer handshake (CLRT1/CLRT2/T1DONE/T2DONE) with internal parametrised timers.
- Adds a saturating token credit counter, basic/deluxe wash modes with repeated soap passes, and operator abort.
- Sits between the coin/button front panel and the soap and spray valve drivers.

Parameters:
- SPRAY_CYCLES, 8: pre-spray phase length in clk cycles (>=1).
- SOAP_CYCLES, 12: soap phase length per pass (>=1).
- RINSE_CYCLES, 6: rinse phase length per pass (>=1).
- SOAP_PASSES, 2: soap+rinse passes in deluxe mode (>=1).
- MAX_CREDITS, 7: credit counter saturation value (>=2).
- BASIC_COST, 1: credits consumed by a basic wash.
- DELUXE_COST, 2: credits consumed by a deluxe wash.

Ports:
- clk  in  1  system clock, all state on rising edge.
- CLR  in  1  asynchronous active-high reset.
- TOKEN  in  1  one-cycle pulse per inserted token.
- START  in  1  start request, sampled in IDLE only.
- DELUXE  in  1  mode select sampled with START: 1=deluxe, 0=basic.
- ABORT  in  1  operator abort, honoured in any wash state.
- SOAP  out  1  soap valve.
- SPRAY  out  1  spray valve.
- BUSY  out  1  high in any non-IDLE state.
- DONE  out  1  one-cycle pulse on normal wash completion.
- CREDITS  out  $clog2(MAX_CREDITS+1)  current credit count.
- PASS  out  $clog2(SOAP_PASSES+1)  current soap pass, 1-based; 0 outside SOAP/RINSE of a deluxe wash.

Behaviour:
- Reset (CLR=1, asynchronous):
  - state=IDLE, credits=0, timer=0, pass=0.
  - SOAP, SPRAY, BUSY, DONE all 0.
  - Reset takes effect immediately, including mid-wash. No refund is given.
- States (one-hot): IDLE, PRESPRAY, SOAP_ST, RINSE.
- Phase timing: the timer loads LEN-1 on state entry and decrements each cycle. The state exits on the edge where timer==0, so every phase lasts exactly LEN cycles.
- Outputs are Moore decodes of state:
  - SPRAY=1 in PRESPRAY and RINSE.
  - SOAP=1 in SOAP_ST.
  - SOAP and SPRAY are never both 1.
- IDLE:
  - START=1, DELUXE=0, credits>=BASIC_COST: go to RINSE, basic wash.
  - START=1, DELUXE=1, credits>=DELUXE_COST: go to PRESPRAY, deluxe wash.
  - Insufficient credits: START is ignored and the state stays IDLE.
- PRESPRAY: on expiry, go to SOAP_ST with pass=1.
- SOAP_ST: on expiry, go to RINSE.
- RINSE, on expiry:
  - Deluxe with pass<SOAP_PASSES: pass+1, go to SOAP_ST.
  - Otherwise: go to IDLE, pass=0, DONE=1 for the next single cycle (registered).
- Credits:
  - The START check uses the registered credit value; a same-cycle TOKEN does not count toward it.
  - Next credits = credits + TOKEN - cost(if start accepted), computed one bit wider, then clamped to MAX_CREDITS.
  - TOKEN is accepted in every state, including mid-wash. Extra tokens at MAX_CREDITS are lost.
- ABORT in PRESPRAY, SOAP_ST or RINSE:
  - Next state is IDLE; outputs go low from that cycle.
  - pass=0, no DONE pulse, no refund.
  - ABORT has priority over timer expiry. ABORT in IDLE has no effect.
- START during a wash is ignored. DELUXE is latched at start; later changes have no effect.
- Unreachable or illegal state encoding recovers to IDLE on the next edge.

Decomposition:
- Package carwash_pkg:
  - state_t, the one-hot enum IDLE/PRESPRAY/SOAP_ST/RINSE.
  - mode_t, BASIC/DELUXE.
  - function cnt_w(n), returning $clog2(n+1).
- Sub-module carwash_timer:
  - Parameter W.
  - Inputs load and value[W-1:0]; output zero.
  - Synchronous load, decrement to 0 and hold.
  - Same async CLR, clk.
  - Sized for max(SPRAY_CYCLES, SOAP_CYCLES, RINSE_CYCLES).

Test Plan:
1. Basic wash: CLR pulse, TOKEN 1 cycle, then START (DELUXE=0) -> SPRAY high exactly 6 cycles, SOAP never high, DONE one cycle after, CREDITS 1->0, BUSY 6 cycles.
2. Deluxe wash: 2 TOKENs, then START+DELUXE -> SPRAY 8, SOAP 12 (PASS=1), SPRAY 6, SOAP 12 (PASS=2), SPRAY 6, then DONE; BUSY 44 cycles, CREDITS 2->0.
3. Credit rules:
   - 9 TOKEN pulses -> CREDITS=7.
   - With CREDITS=1, START+DELUXE -> stays IDLE, CREDITS=1.
   - With CREDITS=0, TOKEN and START in the same cycle -> no start, CREDITS=1.
4. Abort: ABORT on 5th cycle of first SOAP_ST -> IDLE next cycle, SOAP=SPRAY=0, PASS=0, no DONE, CREDITS unchanged. ABORT and timer expiry in the same cycle -> IDLE.
5. Async reset mid-wash: assert CLR between clock edges during RINSE with CREDITS=3 -> outputs and CREDITS go to 0 before the next edge. Normal operation resumes after release.
6. Tokens during a wash: 3 TOKENs during a basic wash -> CREDITS=3 at DONE. A START during the wash is ignored.

Source files
------------

// File: rtl/carwash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : carwash_pkg
// Purpose  : Shared types and helpers for the car-wash controller.
// Revision : 1.0 - initial release
// ============================================================================
package carwash_pkg;

  // One-hot wash phases
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    PRESPRAY = 4'b0010,
    SOAP_ST  = 4'b0100,
    RINSE    = 4'b1000
  } state_t;

  // Wash program latched at start
  typedef enum logic {
    MODE_BASIC  = 1'b0,
    MODE_DELUXE = 1'b1
  } mode_t;

  // Bits needed to hold values 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/carwash_timer.sv
`default_nettype none
// ============================================================================
// Module   : carwash_timer
// Purpose  : Loadable down-counter that stops at zero; flags phase expiry.
// Revision : 1.0 - initial release
// ============================================================================
module carwash_timer
  import carwash_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         CLR,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_q;

  // Load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/carwash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : carwash_ctrl
// Purpose  : Car-wash sequencer with token credits, basic/deluxe programs,
//            internal phase timers and operator abort.
// Revision : 1.0 - initial release
// ============================================================================
module carwash_ctrl
  import carwash_pkg::*;
#(
  parameter int SPRAY_CYCLES = 8,
  parameter int SOAP_CYCLES  = 12,
  parameter int RINSE_CYCLES = 6,
  parameter int SOAP_PASSES  = 2,
  parameter int MAX_CREDITS  = 7,
  parameter int BASIC_COST   = 1,
  parameter int DELUXE_COST  = 2
) (
  input  logic                              clk,
  input  logic                              CLR,
  input  logic                              TOKEN,
  input  logic                              START,
  input  logic                              DELUXE,
  input  logic                              ABORT,
  output logic                              SOAP,
  output logic                              SPRAY,
  output logic                              BUSY,
  output logic                              DONE,
  output logic [cnt_w(MAX_CREDITS)-1:0]     CREDITS,
  output logic [cnt_w(SOAP_PASSES)-1:0]     PASS
);

  localparam int CW     = cnt_w(MAX_CREDITS);
  localparam int PW     = cnt_w(SOAP_PASSES);
  localparam int MAXLEN = (SPRAY_CYCLES > SOAP_CYCLES) ?
                          ((SPRAY_CYCLES > RINSE_CYCLES) ? SPRAY_CYCLES : RINSE_CYCLES) :
                          ((SOAP_CYCLES  > RINSE_CYCLES) ? SOAP_CYCLES  : RINSE_CYCLES);
  localparam int TW     = cnt_w(MAXLEN);

  // Timer reload values: a phase of LEN cycles starts at LEN-1
  localparam logic [TW-1:0] C_SPRAY_LD = TW'(SPRAY_CYCLES - 1);
  localparam logic [TW-1:0] C_SOAP_LD  = TW'(SOAP_CYCLES - 1);
  localparam logic [TW-1:0] C_RINSE_LD = TW'(RINSE_CYCLES - 1);
  localparam logic [CW:0]   C_BASIC    = (CW+1)'(BASIC_COST);
  localparam logic [CW:0]   C_DELUXE   = (CW+1)'(DELUXE_COST);
  localparam logic [CW:0]   C_MAX      = (CW+1)'(MAX_CREDITS);
  localparam logic [PW-1:0] C_PASSES   = PW'(SOAP_PASSES);

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          done_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic [CW:0]   cost;
  logic [CW:0]   credit_sum;

  carwash_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .CLR   (CLR),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // Next-state, pass, timer-load and credit arithmetic
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    cost     = '0;
    case (state_q)
      IDLE: begin
        // Start check uses registered credits, so a same-cycle token cannot fund it
        if (START && !DELUXE && ({1'b0, credits_q} >= C_BASIC)) begin
          state_d  = RINSE;
          mode_d   = MODE_BASIC;
          cost     = C_BASIC;
          tmr_load = 1'b1;
          tmr_val  = C_RINSE_LD;
        end else if (START && DELUXE && ({1'b0, credits_q} >= C_DELUXE)) begin
          state_d  = PRESPRAY;
          mode_d   = MODE_DELUXE;
          cost     = C_DELUXE;
          tmr_load = 1'b1;
          tmr_val  = C_SPRAY_LD;
        end
      end
      PRESPRAY: begin
        if (ABORT) begin
          state_d = IDLE;
          pass_d  = '0;
        end else if (tmr_zero) begin
          state_d  = SOAP_ST;
          pass_d   = PW'(1);
          tmr_load = 1'b1;
          tmr_val  = C_SOAP_LD;
        end
      end
      SOAP_ST: begin
        if (ABORT) begin
          state_d = IDLE;
          pass_d  = '0;
        end else if (tmr_zero) begin
          state_d  = RINSE;
          tmr_load = 1'b1;
          tmr_val  = C_RINSE_LD;
        end
      end
      RINSE: begin
        if (ABORT) begin
          state_d = IDLE;
          pass_d  = '0;
        end else if (tmr_zero) begin
          if (mode_q == MODE_DELUXE && pass_q < C_PASSES) begin
            state_d  = SOAP_ST;
            pass_d   = pass_q + PW'(1);
            tmr_load = 1'b1;
            tmr_val  = C_SOAP_LD;
          end else begin
            state_d = IDLE;
            pass_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pass_d  = '0;
      end
    endcase
    // Cost never exceeds credits, so the wide sum cannot underflow
    credit_sum = {1'b0, credits_q} + {{CW{1'b0}}, TOKEN} - cost;
    credits_d  = (credit_sum > C_MAX) ? C_MAX[CW-1:0] : credit_sum[CW-1:0];
  end

  // State and registered Moore outputs decoded from the next state
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q   <= IDLE;
      mode_q    <= MODE_BASIC;
      credits_q <= '0;
      pass_q    <= '0;
      SOAP      <= 1'b0;
      SPRAY     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      credits_q <= credits_d;
      pass_q    <= pass_d;
      SOAP      <= (state_d == SOAP_ST);
      SPRAY     <= (state_d == PRESPRAY) || (state_d == RINSE);
      BUSY      <= (state_d != IDLE);
      DONE      <= done_d;
    end
  end

  assign CREDITS = credits_q;
  assign PASS    = pass_q;

endmodule
`default_nettype wire
